paddle_position: RTL and testbench

Paddle position register for the Pong datapath. It sits on the output side of the paddle move limiter: it consumes the per-frame signed step `dx` and integrates it into the paddle centre coordinate `actual_pos`, which feeds back to the limiter and forward to rendering and collision. It adds hold-to-accelerate (fast mode after sustained motion), defensive clamping to the playfield, and a recenter request/done handshake used after a point is scored.

---
 rtl/paddle_position.sv | 163 ++++++++++++++++
 tb/tb_paddle_position.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_position.sv
// rtl/paddle_position.sv - paddle centre integrator with hold-to-accelerate, playfield clamp and recenter handshake
module paddle_position #(
    parameter int WIDTH      = 17,
    parameter int CENTER     = 64,
    parameter int FAST_AFTER = 8,
    parameter int FAST_STEP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] dx,
    input  logic       recenter_req,
    output logic [6:0] actual_pos,
    output logic       moving,
    output logic       recentering,
    output logic       recenter_done,
    output logic       at_min,
    output logic       at_max
);

    localparam int MIN_P = WIDTH / 2;
    localparam int MAX_P = 127 - WIDTH / 2;
    localparam int RW    = $clog2(FAST_AFTER + 1);

    localparam logic [6:0]        MIN_POS  = 7'(MIN_P);
    localparam logic [6:0]        MAX_POS  = 7'(MAX_P);
    localparam logic [6:0]        CTR_POS  = 7'(CENTER);
    localparam logic signed [8:0] MIN9     = 9'(MIN_P);
    localparam logic signed [8:0] MAX9     = 9'(MAX_P);
    localparam logic [RW-1:0]     RUN_MAX  = RW'(FAST_AFTER);
    localparam logic [RW-1:0]     RUN_ONE  = RW'(1);
    localparam logic [2:0]        FAST_MAG = 3'(FAST_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLOW,
        S_FAST,
        S_RECENTER
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      pos_q, pos_d;
    logic            dir_q, dir_d;
    logic [RW-1:0]   run_cnt_q, run_cnt_d;
    logic            moving_q, moving_d;
    logic            recentering_q, recentering_d;
    logic            done_q, done_d;

    logic            dx_pos, dx_neg, dx_valid, blocked, same_dir;
    logic            step_neg;
    logic [2:0]      step_mag;
    logic signed [8:0] pos9, mag9, sum9;
    logic [6:0]      next_pos;
    logic [RW-1:0]   run_inc;

    // Only exact +1 / -1 requests move the paddle; dir_q=1 means negative.
    always_comb begin
        dx_pos   = (dx == 3'b001);
        dx_neg   = (dx == 3'b111);
        dx_valid = dx_pos | dx_neg;
        blocked  = (dx_neg && pos_q == MIN_POS) || (dx_pos && pos_q == MAX_POS);
        same_dir = (state_q == S_SLOW || state_q == S_FAST) && (dx_neg == dir_q);
        run_inc  = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + RUN_ONE;
    end

    always_comb begin
        step_neg = dx_neg;
        step_mag = 3'd1;
        if (state_q == S_RECENTER) begin
            step_neg = (pos_q > CTR_POS);
        end else if (state_q == S_FAST && same_dir) begin
            step_mag = FAST_MAG;
        end
    end

    // Signed 9-bit sum so a step past either edge clamps instead of wrapping.
    always_comb begin
        pos9 = $signed({2'b00, pos_q});
        mag9 = $signed({6'b000000, step_mag});
        sum9 = step_neg ? (pos9 - mag9) : (pos9 + mag9);
        if (sum9 < MIN9) begin
            next_pos = MIN_POS;
        end else if (sum9 > MAX9) begin
            next_pos = MAX_POS;
        end else begin
            next_pos = sum9[6:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        run_cnt_d = run_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            S_RECENTER: begin
                if (pos_q == CTR_POS) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    pos_d = next_pos;
                end
            end
            default: begin
                if (recenter_req) begin
                    // A coincident tick is deliberately dropped.
                    state_d   = S_RECENTER;
                    run_cnt_d = '0;
                end else if (tick) begin
                    if (!dx_valid || blocked) begin
                        state_d   = S_IDLE;
                        run_cnt_d = '0;
                    end else if (state_q == S_IDLE || !same_dir) begin
                        pos_d     = next_pos;
                        dir_d     = dx_neg;
                        run_cnt_d = RUN_ONE;
                        state_d   = S_SLOW;
                    end else if (state_q == S_SLOW) begin
                        pos_d     = next_pos;
                        run_cnt_d = run_inc;
                        if (run_inc == RUN_MAX) begin
                            state_d = S_FAST;
                        end
                    end else begin
                        pos_d     = next_pos;
                        run_cnt_d = run_inc;
                    end
                end
            end
        endcase
        moving_d      = (state_d == S_SLOW) || (state_d == S_FAST);
        recentering_d = (state_d == S_RECENTER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pos_q         <= CTR_POS;
            dir_q         <= 1'b0;
            run_cnt_q     <= '0;
            moving_q      <= 1'b0;
            recentering_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            run_cnt_q     <= run_cnt_d;
            moving_q      <= moving_d;
            recentering_q <= recentering_d;
            done_q        <= done_d;
        end
    end

    assign actual_pos    = pos_q;
    assign moving        = moving_q;
    assign recentering   = recentering_q;
    assign recenter_done = done_q;
    assign at_min        = (pos_q == MIN_POS);
    assign at_max        = (pos_q == MAX_POS);

endmodule

// File: tb/tb_paddle_position.sv
// tb/tb_paddle_position.sv - directed and randomized checks of paddle_position against a behavioural model
module tb_paddle_position;

    logic       clk = 1'b0;
    logic       rst, tick, recenter_req;
    logic [2:0] dx;
    logic [6:0] actual_pos;
    logic       moving, recentering, recenter_done, at_min, at_max;

    paddle_position dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .dx           (dx),
        .recenter_req (recenter_req),
        .actual_pos   (actual_pos),
        .moving       (moving),
        .recentering  (recentering),
        .recenter_done(recenter_done),
        .at_min       (at_min),
        .at_max       (at_max)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    localparam int M_IDLE = 0, M_SLOW = 1, M_FAST = 2, M_REC = 3;
    int m_pos  = 64;
    int m_mode = M_IDLE;
    int m_dir  = 1;
    int m_run  = 0;
    bit m_done = 1'b0;

    function automatic int clampi(input int v);
        if (v < 8) return 8;
        if (v > 119) return 119;
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: position as a plain integer, modes as small ints.
    always @(posedge clk) begin
        int s;
        if (rst) begin
            m_pos = 64; m_mode = M_IDLE; m_run = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_mode == M_REC) begin
                if (m_pos == 64) begin
                    m_mode = M_IDLE; m_done = 1'b1;
                end else if (tick) begin
                    m_pos = m_pos + ((m_pos < 64) ? 1 : -1);
                end
            end else if (recenter_req) begin
                m_mode = M_REC; m_run = 0;
            end else if (tick) begin
                s = (dx == 3'b001) ? 1 : (dx == 3'b111) ? -1 : 0;
                if (s == 0 || (s < 0 && m_pos == 8) || (s > 0 && m_pos == 119)) begin
                    m_mode = M_IDLE; m_run = 0;
                end else if (m_mode == M_IDLE || s != m_dir) begin
                    m_pos = clampi(m_pos + s); m_dir = s; m_run = 1; m_mode = M_SLOW;
                end else if (m_mode == M_SLOW) begin
                    m_pos = clampi(m_pos + s); m_run++;
                    if (m_run >= 8) m_mode = M_FAST;
                end else begin
                    m_pos = clampi(m_pos + 2 * s);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_pos", actual_pos, m_pos);
            cmp("model_moving", moving, (m_mode == M_SLOW || m_mode == M_FAST) ? 1 : 0);
            cmp("model_recentering", recentering, (m_mode == M_REC) ? 1 : 0);
            cmp("model_done", recenter_done, m_done);
            cmp("model_at_min", at_min, (m_pos == 8) ? 1 : 0);
            cmp("model_at_max", at_max, (m_pos == 119) ? 1 : 0);
        end
    end

    task automatic cyc(input bit t, input logic [2:0] d, input bit r, input bit rs);
        tick = t; dx = d; recenter_req = r; rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_acc[10];
        logic [2:0] d;
        exp_acc = '{65, 66, 67, 68, 69, 70, 71, 72, 74, 76};
        rst = 1'b1; tick = 1'b0; dx = 3'b000; recenter_req = 1'b0;

        cyc(0, 3'b000, 0, 1);
        cyc(0, 3'b000, 0, 1);
        check_en = 1'b1;
        cmp("reset_pos", actual_pos, 64);
        cmp("reset_moving", moving, 0);
        cmp("reset_recentering", recentering, 0);
        cmp("reset_done", recenter_done, 0);
        cmp("reset_at_min", at_min, 0);
        cmp("reset_at_max", at_max, 0);
        cyc(0, 3'b000, 0, 0);

        for (int i = 0; i < 10; i++) begin
            cyc(1, 3'b001, 0, 0);
            cmp("accel_pos", actual_pos, exp_acc[i]);
            cmp("accel_moving", moving, 1);
        end

        for (int i = 0; i < 21; i++) cyc(1, 3'b001, 0, 0);
        cmp("fast_118", actual_pos, 118);
        cyc(1, 3'b001, 0, 0);
        cmp("clamp_max_pos", actual_pos, 119);
        cmp("clamp_at_max", at_max, 1);
        cyc(1, 3'b001, 0, 0);
        cmp("blocked_max_pos", actual_pos, 119);
        cmp("blocked_max_moving", moving, 0);

        for (int i = 0; i < 8; i++) cyc(1, 3'b111, 0, 0);
        cmp("down_111", actual_pos, 111);
        for (int i = 0; i < 50; i++) cyc(1, 3'b111, 0, 0);
        cmp("down_11", actual_pos, 11);
        cyc(1, 3'b000, 0, 0);
        cyc(1, 3'b111, 0, 0);
        cyc(1, 3'b111, 0, 0);
        cmp("slow_9", actual_pos, 9);
        cyc(1, 3'b111, 0, 0);
        cmp("clamp_min_pos", actual_pos, 8);
        cmp("clamp_at_min", at_min, 1);
        cyc(1, 3'b111, 0, 0);
        cmp("blocked_min_pos", actual_pos, 8);
        cmp("blocked_min_moving", moving, 0);
        cmp("blocked_min_at_min", at_min, 1);

        for (int i = 0; i < 8; i++) cyc(1, 3'b001, 0, 0);
        for (int i = 0; i < 32; i++) cyc(1, 3'b001, 0, 0);
        cmp("fast_80", actual_pos, 80);
        cyc(1, 3'b111, 0, 0);
        cmp("reverse_pos", actual_pos, 79);
        cmp("reverse_moving", moving, 1);
        cyc(1, 3'b010, 0, 0);
        cmp("invalid_dx_pos", actual_pos, 79);
        cmp("invalid_dx_moving", moving, 0);

        cyc(1, 3'b001, 0, 0);
        cyc(1, 3'b000, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 3'b001, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 3'b001, 0, 0);
        cmp("reach_100", actual_pos, 100);

        cyc(1, 3'b001, 1, 0);
        cmp("rc_req_pos", actual_pos, 100);
        cmp("rc_req_flag", recentering, 1);
        for (int i = 0; i < 36; i++) begin
            cyc(1, 3'b001, 0, 0);
            cmp("rc_step_pos", actual_pos, 99 - i);
            cmp("rc_step_flag", recentering, 1);
        end
        cyc(1, 3'b001, 0, 0);
        cmp("rc_end_flag", recentering, 0);
        cmp("rc_end_done", recenter_done, 1);
        cmp("rc_end_moving", moving, 0);
        cyc(0, 3'b000, 0, 0);
        cmp("rc_done_single", recenter_done, 0);

        cyc(0, 3'b000, 1, 0);
        cmp("rc64_flag", recentering, 1);
        cmp("rc64_done_early", recenter_done, 0);
        cyc(0, 3'b000, 0, 0);
        cmp("rc64_flag_end", recentering, 0);
        cmp("rc64_done", recenter_done, 1);
        cyc(0, 3'b000, 0, 0);
        cmp("rc64_done_single", recenter_done, 0);

        for (int i = 0; i < 6; i++) cyc(1, 3'b001, 0, 0);
        cmp("reach_70", actual_pos, 70);
        cyc(1, 3'b001, 1, 0);
        cmp("simul_pos", actual_pos, 70);
        cmp("simul_flag", recentering, 1);
        cyc(1, 3'b001, 0, 0);
        cyc(1, 3'b001, 0, 0);
        cmp("rc_mid_68", actual_pos, 68);
        cyc(1, 3'b001, 0, 1);
        cmp("rst_mid_pos", actual_pos, 64);
        cmp("rst_mid_flag", recentering, 0);
        cmp("rst_mid_done", recenter_done, 0);
        cmp("rst_mid_moving", moving, 0);
        cyc(0, 3'b000, 0, 0);
        cmp("rst_mid_no_done", recenter_done, 0);

        d = 3'b001;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 20) begin
                case ($urandom_range(0, 5))
                    0, 1:    d = 3'b001;
                    2, 3:    d = 3'b111;
                    default: d = 3'($urandom_range(0, 7));
                endcase
            end
            cyc($urandom_range(0, 2) != 0, d, $urandom_range(0, 79) == 0,
                $urandom_range(0, 599) == 0);
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
